// File: rtl/aes_pkg.sv
//==============================================================================
// Module   : aes_pkg
// Brief    : Shared AES column-mixing types, mode encodings and GF(2^8) helpers.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  column_t;
    typedef logic [1:0]   mode_t;

    localparam mode_t      MODE_FWD = 2'b00;
    localparam mode_t      MODE_INV = 2'b01;
    localparam mode_t      MODE_BYP = 2'b10;
    localparam logic [7:0] GF_POLY  = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // Only the coefficients used by the two matrices are decoded; anything else is identity.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            4'h2:    return x2;
            4'h3:    return x2 ^ a;
            4'h9:    return x8 ^ a;
            4'hB:    return x8 ^ x2 ^ a;
            4'hD:    return x8 ^ x4 ^ a;
            4'hE:    return x8 ^ x4 ^ x2;
            default: return a;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mix_column.sv
//==============================================================================
// Module   : mix_column
// Brief    : Combinational MixColumns / InvMixColumns on one 32-bit column.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mix_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    input  logic        i_inv,
    output logic [31:0] o_col
);

    localparam logic [3:0] C_FWD [4] = '{4'h2, 4'h3, 4'h1, 4'h1};
    localparam logic [3:0] C_INV [4] = '{4'hE, 4'hB, 4'hD, 4'h9};

    logic [7:0] w_a [4];
    logic [7:0] w_b [4];

    // Row r uses the base coefficient row rotated right by r.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w_a[r] = i_col[31-8*r -: 8];
        end
        for (int r = 0; r < 4; r++) begin
            w_b[r] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                w_b[r] = w_b[r] ^ gf_mul_const(w_a[j], i_inv ? C_INV[2'(j - r)] : C_FWD[2'(j - r)]);
            end
        end
        o_col = {w_b[0], w_b[1], w_b[2], w_b[3]};
    end

endmodule

`default_nettype wire

// File: rtl/mix_columns_engine.sv
//==============================================================================
// Module   : mix_columns_engine
// Brief    : Sequential AES (Inv)MixColumns / bypass engine, COLS_PER_CYCLE columns per clock.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int         NSTEP      = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] C_COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] C_COL_LAST = 2'(COLS_PER_CYCLE * (NSTEP - 1));

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    state_t     work_q, work_d;
    logic       inv_q, inv_d;
    logic [1:0] col_idx_q, col_idx_d;
    logic       w_accept;

    column_t w_cols     [4];
    column_t w_mix_out  [COLS_PER_CYCLE];

    for (genvar c = 0; c < 4; c++) begin : g_cols
        assign w_cols[c] = work_q[127-32*c -: 32];
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
        logic [1:0] w_sel;
        assign w_sel = col_idx_q + 2'(g);
        mix_column u_mix_column (
            .i_col (w_cols[w_sel]),
            .i_inv (inv_q),
            .o_col (w_mix_out[g])
        );
    end

    assign in_ready  = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && out_ready);
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q == S_RUN) || (fsm_q == S_DONE);
    assign state_out = work_q;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        fsm_d     = fsm_q;
        work_d    = work_q;
        inv_d     = inv_q;
        col_idx_d = col_idx_q;
        case (fsm_q)
            S_IDLE: ;
            S_RUN: begin
                for (int c = 0; c < 4; c++) begin
                    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                        if (col_idx_q + 2'(g) == 2'(c)) begin
                            work_d[127-32*c -: 32] = w_mix_out[g];
                        end
                    end
                end
                col_idx_d = col_idx_q + C_COL_STEP;
                if (col_idx_q == C_COL_LAST) begin
                    col_idx_d = 2'd0;
                    fsm_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        // Accept wins over the DONE retire so a back-to-back state is never dropped.
        if (w_accept) begin
            work_d    = state_in;
            inv_d     = (mode == MODE_INV);
            col_idx_d = 2'd0;
            fsm_d     = (mode == MODE_FWD || mode == MODE_INV) ? S_RUN : S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q     <= S_IDLE;
            work_q    <= '0;
            inv_q     <= 1'b0;
            col_idx_q <= 2'd0;
        end else begin
            fsm_q     <= fsm_d;
            work_q    <= work_d;
            inv_q     <= inv_d;
            col_idx_q <= col_idx_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Parametrised, sequential successor to the combinational reverse-diffusion stage.
- Performs AES MixColumns (forward), InvMixColumns (inverse) or pass-through (bypass, for the final encrypt round) on a 128-bit state.
- Processes COLS_PER_CYCLE columns per clock behind valid/ready handshakes.
- Sits between the byte-substitution/row-shift stages and AddRoundKey in the round datapath.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; other values are an elaboration error.
- Derived constant NSTEP = 4/COLS_PER_CYCLE: number of RUN cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  state_in and mode are valid.
- in_ready  output  1  engine can accept a state.
- mode  input  2  00 forward, 01 inverse, 10 bypass, 11 reserved (treated as bypass).
- state_in  input  128  FIPS-197 byte order: column c at [127-32c -: 32], row r at [127-32c-8r -: 8].
- out_valid  output  1  state_out holds a finished result.
- out_ready  input  1  downstream accepts the result.
- state_out  output  128  result, same byte order as state_in.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values: in_ready=1, out_valid=0, busy=0, state_out=0, FSM=IDLE, col_idx=0. Reset has priority over every other event.
- Reset mid-operation discards the work in flight; no out_valid pulse is produced for it.
- FSM states are IDLE, RUN and DONE.
- Accept occurs on the edge where in_valid && in_ready are both high. At accept, the engine latches state_in into the working register and latches mode.
  - Forward or inverse mode: transition to RUN with col_idx=0.
  - Bypass mode: transition directly to DONE.
- RUN:
  - Each cycle, replace columns col_idx .. col_idx+COLS_PER_CYCLE-1 in the working register with their transformed values.
  - Advance col_idx by COLS_PER_CYCLE.
  - After NSTEP cycles, col_idx wraps to 0 and the FSM goes to DONE.
  - in_ready=0 throughout RUN.
- Latency from the accept edge to out_valid:
  - NSTEP cycles for forward or inverse (4, 2 or 1).
  - 1 cycle for bypass.
- DONE:
  - out_valid=1; state_out is the working register, held stable until the handshake completes.
  - On out_valid && out_ready, out_valid deasserts next cycle unless a new result is produced on the same edge.
  - in_ready = out_ready while in DONE, so back-to-back operation is supported. A simultaneous output handshake and input accept retires the old result and accepts the new state on the same edge.
- Mode and state_in changes while not accepting are ignored.
- Arithmetic is over GF(2^8) with polynomial 0x11B.
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 0).
  - Forward matrix rows: [2 3 1 1] rotated.
  - Inverse matrix rows: [e b d 9] rotated.
  - All products are 8-bit; no carries.
- in_valid while reset is high is ignored.

Decomposition:
- Package aes_pkg holds:
  - mode encodings MODE_FWD, MODE_INV, MODE_BYP;
  - constant GF_POLY = 8'h1B;
  - functions xtime and gf_mul_const (coefficients 2, 3, 9, b, d, e);
  - the state_t and column_t typedefs (128/32-bit).
- Sub-module mix_column: combinational, 32-bit column in, a 1-bit inv select, 32-bit column out.
- Instantiate mix_column COLS_PER_CYCLE times in a generate loop. The column mux and demux use col_idx.

Test Plan:
- Forward, COLS_PER_CYCLE=1: state_in columns db135345 f20a225c 01010101 c6c6c6c6 -> out_valid exactly 4 cycles after accept; state_out = 8e4da1bc 9fdc589d 01010101 c6c6c6c6.
- Inverse, COLS_PER_CYCLE=4: state_in 8e4da1bc 9fdc589d d5d5d7d6 4d7ebdf8 -> out_valid 1 cycle after accept; state_out = db135345 f20a225c d4d4d4d5 2d26314c.
- Bypass and reserved mode (mode=10 then 11): arbitrary state -> out_valid after 1 cycle; state_out equals state_in bit-exact in both cases.
- Backpressure and back-to-back, COLS_PER_CYCLE=2:
  - Hold out_ready=0 for 5 cycles -> state_out and out_valid stay stable and in_ready=0.
  - Then raise out_ready together with in_valid -> the first result retires and the second state is accepted on the same edge.
  - The second result appears 2 cycles later.
- Reset mid-RUN (COLS_PER_CYCLE=1, reset after 2 RUN cycles):
  - Outputs return to their reset values next cycle, with no out_valid pulse.
  - A subsequent forward op on d4d4d4d5 x4 yields d5d5d7d6 x4.
- Round trip: 100 random states through forward then inverse for each COLS_PER_CYCLE -> output equals the original state.
